// File: rtl/serial_word_comparator_pkg.sv
// Shared types and sizing helpers for the serial word comparator.
package serial_word_comparator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int digits_of(input int width);
        return width / 2;
    endfunction

    // Counter must hold DIGITS-1; keep at least one bit for the single-digit case.
    function automatic int cnt_width(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

// File: rtl/serial_word_comparator_cmp2.sv
// Existing 2-bit magnitude compare stage: one-hot GT/LT/EQ for a single digit.
module comparator_2bit (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       gt,
    output logic       lt,
    output logic       eq
);

    assign gt = (a > b);
    assign lt = (a < b);
    assign eq = (a == b);

endmodule

// File: rtl/serial_word_comparator.sv
// Multi-cycle unsigned magnitude comparator: walks 2-bit digits MSB first and exits at the first difference.
module serial_word_comparator
    import serial_word_comparator_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gt,
    output logic             lt,
    output logic             eq,
    output logic             busy
);

    localparam int DIGITS = digits_of(WIDTH);
    localparam int CNT_W  = cnt_width(DIGITS);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DIGITS - 1);

    generate
        if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_width_check
            $error("serial_word_comparator: WIDTH must be even and >= 2");
        end
    endgenerate

    state_t           state, state_d;
    logic [WIDTH-1:0] sa, sa_d;
    logic [WIDTH-1:0] sb, sb_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             gt_d, lt_d, eq_d;
    logic             dig_gt, dig_lt, dig_eq;

    comparator_2bit u_cmp (
        .a  (sa[WIDTH-1:WIDTH-2]),
        .b  (sb[WIDTH-1:WIDTH-2]),
        .gt (dig_gt),
        .lt (dig_lt),
        .eq (dig_eq)
    );

    assign in_ready  = (state == IDLE);
    assign busy      = (state == RUN);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            cnt   <= '0;
            gt    <= 1'b0;
            lt    <= 1'b0;
            eq    <= 1'b0;
        end else begin
            state <= state_d;
            sa    <= sa_d;
            sb    <= sb_d;
            cnt   <= cnt_d;
            gt    <= gt_d;
            lt    <= lt_d;
            eq    <= eq_d;
        end
    end

    always_comb begin
        state_d = state;
        sa_d    = sa;
        sb_d    = sb;
        cnt_d   = cnt;
        gt_d    = gt;
        lt_d    = lt;
        eq_d    = eq;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    sa_d    = a;
                    sb_d    = b;
                    cnt_d   = CNT_INIT;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    eq_d    = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // dig_eq is implied by neither GT nor LT; the digit decision only needs those two.
                if (dig_gt || dig_lt) begin
                    gt_d    = dig_gt;
                    lt_d    = dig_lt;
                    state_d = DONE;
                end else if (cnt == '0) begin
                    eq_d    = dig_eq;
                    state_d = DONE;
                end else begin
                    sa_d  = sa << 2;
                    sb_d  = sb << 2;
                    cnt_d = cnt - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_serial_word_comparator.sv
// Directed scoreboard bench for serial_word_comparator (WIDTH = 8).
module tb_serial_word_comparator;

    localparam int WIDTH  = 8;
    localparam int DIGITS = WIDTH / 2;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic             gt;
    logic             lt;
    logic             eq;
    logic             busy;

    typedef struct {
        logic gt;
        logic lt;
        logic eq;
        int   k;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    serial_word_comparator #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .gt        (gt),
        .lt        (lt),
        .eq        (eq),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: magnitude relation plus the 1-based index of the first differing digit.
    function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb);
        exp_t e;
        e.gt = (ma > mb);
        e.lt = (ma < mb);
        e.eq = (ma == mb);
        e.k  = DIGITS;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (ma[2*i +: 2] != mb[2*i +: 2]) begin
                e.k = DIGITS - i;
                break;
            end
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one operand pair, measure latency/busy, check result, optionally stall out_ready for 'hold' cycles.
    task automatic run_txn(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input int hold);
        exp_t e;
        int   lat;
        int   busy_n;
        logic hgt, hlt, heq;
        exp_q.push_back(model(ta, tb));
        out_ready = 1'b1;
        chk({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a        = ta;
        b        = tb;
        step();
        in_valid = 1'b0;
        a        = WIDTH'($urandom);
        b        = WIDTH'($urandom);
        lat    = 0;
        busy_n = 0;
        while (!out_valid && lat < 20) begin
            if (busy) busy_n++;
            step();
            lat++;
        end
        e = exp_q.pop_front();
        if (hold > 0) out_ready = 1'b0;
        chk({tag, "_latency"}, 32'(lat), 32'(e.k));
        chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(e.k));
        chk({tag, "_gt"}, 32'(gt), 32'(e.gt));
        chk({tag, "_lt"}, 32'(lt), 32'(e.lt));
        chk({tag, "_eq"}, 32'(eq), 32'(e.eq));
        chk({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
        hgt = gt;
        hlt = lt;
        heq = eq;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a        = 8'hFF;
            b        = 8'h00;
            step();
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_result"}, 32'({gt, lt, eq}), 32'({hgt, hlt, heq}));
            chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk({tag, "_post_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_post_result"}, 32'({gt, lt, eq}), 32'({e.gt, e.lt, e.eq}));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        repeat (2) step();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", 32'({gt, lt, eq}), 32'd0);
        rst_n = 1'b1;
        step();

        run_txn("equal", 8'hA5, 8'hA5, 0);
        run_txn("early_gt", 8'hC0, 8'h40, 0);
        run_txn("late_lt", 8'h12, 8'h13, 0);
        run_txn("backpressure", 8'h00, 8'hFF, 5);

        // Abort mid-RUN: no result must surface.
        in_valid = 1'b1;
        a        = 8'h01;
        b        = 8'h02;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("abort_result", 32'({gt, lt, eq}), 32'd0);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("abort_no_valid", 32'(out_valid), 32'd0);
        end
        run_txn("after_abort_eq", 8'h03, 8'h03, 0);

        // Next accept lands on the edge right after the IDLE cycle that follows the handshake.
        run_txn("b2b_gt", 8'h80, 8'h7F, 0);
        run_txn("b2b_lt", 8'h7F, 8'h80, 0);

        run_txn("lsb_gt", 8'h3E, 8'h3D, 0);
        run_txn("zero_eq", 8'h00, 8'h00, 0);
        run_txn("max_eq", 8'hFF, 8'hFF, 1);
        run_txn("digit2_lt", 8'h4F, 8'h6F, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
